// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle datapath: fetch/decode/execute/memory/writeback
// sequencing, memory handshake with timeout, illegal-opcode trap and retired counter.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [31:0]      i_instr,
  input  logic             i_zero,
  input  logic             i_mem_ready,
  output logic             o_mem_read,
  output logic             o_mem_write,
  output logic             o_iord,
  output logic             o_ir_write,
  output logic             o_pc_write,
  output logic [1:0]       o_pc_src,
  output logic             o_alu_src_b,
  output logic [1:0]       o_alu_type,
  output logic [4:0]       o_alu_func,
  output logic             o_reg_write,
  output logic             o_mem_to_reg,
  output logic [3:0]       o_state,
  output logic             o_trap,
  output logic [1:0]       o_trap_cause,
  output logic [CNT_W-1:0] o_retired
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_EXEC_S   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_WB_ALU   = 4'd8,
    S_WB_MEM   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  localparam int TO_W = $clog2(MEM_TIMEOUT + 1);

  state_t           r_state;
  state_t           w_next;
  logic [TO_W-1:0]  r_wait_cnt;
  logic [CNT_W-1:0] r_retired;
  logic             r_trap;
  logic [1:0]       r_trap_cause;

  logic [1:0] w_type;
  logic [4:0] w_func;
  logic       w_mem_state;
  logic       w_timeout;
  logic       w_retire;
  logic [1:0] w_cause;

  assign w_type      = i_instr[31:30];
  assign w_func      = i_instr[29:25];
  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  // Trap on the wait cycle that would bring the count to MEM_TIMEOUT; a late mem_ready still wins.
  assign w_timeout   = w_mem_state && !i_mem_ready && (r_wait_cnt == TO_W'(MEM_TIMEOUT - 1));
  assign w_cause     = (r_state == S_DECODE) ? 2'b01 : 2'b10;

  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    case (r_state)
      S_FETCH:  if (i_mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        w_next = S_TRAP;
        case (w_type)
          2'b00: if (w_func <= 5'd3) w_next = S_EXEC_R;
          2'b01: if (w_func == 5'd0) w_next = S_JUMP;
          2'b10: begin
            if (w_func <= 5'd1)      w_next = S_EXEC_I;
            else if (w_func <= 5'd3) w_next = S_MEM_ADDR;
            else if (w_func == 5'd4) w_next = S_BRANCH;
          end
          default: if (w_func <= 5'd3) w_next = S_EXEC_S;
        endcase
      end
      S_EXEC_R: begin
        if (w_func == 5'd3) begin
          w_next   = S_FETCH;
          w_retire = 1'b1;
        end else begin
          w_next = S_WB_ALU;
        end
      end
      S_EXEC_I, S_EXEC_S: w_next = S_WB_ALU;
      S_MEM_ADDR: w_next = (w_func == 5'd3) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: if (i_mem_ready) w_next = S_WB_MEM;
      S_MEM_WR: begin
        if (i_mem_ready) begin
          w_next   = S_FETCH;
          w_retire = 1'b1;
        end
      end
      S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      default: w_next = S_TRAP;
    endcase
    if (w_timeout) w_next = S_TRAP;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_FETCH;
      r_wait_cnt   <= '0;
      r_retired    <= '0;
      r_trap       <= 1'b0;
      r_trap_cause <= 2'b00;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_wait_cnt <= '0;
      else if (w_mem_state && !i_mem_ready)
        r_wait_cnt <= r_wait_cnt + 1'b1;
      if (w_retire && (r_retired != '1))
        r_retired <= r_retired + 1'b1;
      if ((w_next == S_TRAP) && (r_state != S_TRAP)) begin
        r_trap       <= 1'b1;
        r_trap_cause <= w_cause;
      end
    end
  end

  always_comb begin
    o_mem_read   = 1'b0;
    o_mem_write  = 1'b0;
    o_iord       = 1'b0;
    o_ir_write   = 1'b0;
    o_pc_write   = 1'b0;
    o_pc_src     = 2'b00;
    o_alu_src_b  = 1'b0;
    o_alu_type   = 2'b00;
    o_alu_func   = 5'b00001;
    o_reg_write  = 1'b0;
    o_mem_to_reg = 1'b0;
    case (r_state)
      S_FETCH: begin
        o_mem_read = 1'b1;
        o_ir_write = i_mem_ready && !i_reset;
        o_pc_write = i_mem_ready && !i_reset;
      end
      S_EXEC_R: o_alu_func = w_func;
      S_EXEC_I, S_MEM_ADDR: begin
        o_alu_type  = 2'b10;
        o_alu_func  = w_func;
        o_alu_src_b = 1'b1;
      end
      S_EXEC_S: begin
        o_alu_type  = 2'b11;
        o_alu_func  = w_func;
        o_alu_src_b = (w_func < 5'd2);
      end
      S_MEM_RD: begin
        o_mem_read = 1'b1;
        o_iord     = 1'b1;
      end
      S_MEM_WR: begin
        o_mem_write = 1'b1;
        o_iord      = 1'b1;
      end
      S_WB_ALU: o_reg_write = 1'b1;
      S_WB_MEM: begin
        o_reg_write  = 1'b1;
        o_mem_to_reg = 1'b1;
      end
      S_BRANCH: begin
        o_alu_func = 5'b00010;
        o_pc_write = i_zero;
        o_pc_src   = 2'b01;
      end
      S_JUMP: begin
        o_pc_write = 1'b1;
        o_pc_src   = 2'b10;
      end
      default: ;
    endcase
  end

  assign o_state      = r_state;
  assign o_trap       = r_trap;
  assign o_trap_cause = r_trap_cause;
  assign o_retired    = r_retired;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle datapath; sequences the shared 32-bit ALU, register file, instruction/data memory and PC through fetch, decode, execute, memory and writeback.
- Decodes the instruction register and drives the ALU InstructionType/Function fields and all datapath enables.
- Handshakes with a variable-latency memory and traps on an illegal opcode or a memory timeout.

Parameters:
- MEM_TIMEOUT, 16, max cycles to wait for mem_ready in any memory state before trapping.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  clock (rising edge).
- reset  in  1  asynchronous, active-high reset.
- instr  in  32  IR contents; [31:30] type (00 R, 01 J, 10 I, 11 S); [29:25] function.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access complete this cycle.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- iord  out  1  memory address select: 0 = PC, 1 = ALU result register.
- ir_write  out  1  load IR.
- pc_write  out  1  load PC.
- pc_src  out  2  PC source: 00 = PC+4, 01 = branch target, 10 = jump target.
- alu_src_b  out  1  ALU B operand: 0 = register, 1 = sign-extended immediate.
- alu_type  out  2  ALU InstructionType.
- alu_func  out  5  ALU Function.
- reg_write  out  1  register-file write enable.
- mem_to_reg  out  1  writeback source: 0 = ALU, 1 = memory data.
- state  out  4  current state code (debug).
- trap  out  1  sticky fault indication.
- trap_cause  out  2  trap cause: 01 = illegal opcode, 10 = memory timeout.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- State codes: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, EXEC_S=4, MEM_ADDR=5, MEM_RD=6, MEM_WR=7, WB_ALU=8, WB_MEM=9, BRANCH=10, JUMP=11, TRAP=12.
- Output style: Moore outputs decoded from the state register. Exceptions: ir_write/pc_write in FETCH are gated by mem_ready, and pc_write in BRANCH is gated by zero.
- Output defaults: all enables 0, pc_src=00, alu_type=00, alu_func=00001 (ADD).
- Reset: state=FETCH, timeout counter=0, retired=0, trap=0, trap_cause=00. Reset mid-operation abandons any pending memory access immediately. While in reset, outputs show FETCH values (mem_read=1, iord=0, all else 0).
- FETCH: mem_read=1, iord=0. When mem_ready=1: ir_write=1, pc_write=1, pc_src=00, next state DECODE; otherwise hold.
- DECODE (1 cycle), branch on type/function:
  - R with function 00000–00011 -> EXEC_R.
  - I function 00000/00001 -> EXEC_I.
  - I function 00010/00011 -> MEM_ADDR.
  - I function 00100 -> BRANCH.
  - S function 00000–00011 -> EXEC_S.
  - J function 00000 -> JUMP.
  - Anything else -> TRAP, cause 01.
- EXEC_R: alu_type=00, alu_func=instr function, alu_src_b=0. CMP (00011) goes to FETCH and retires; all others go to WB_ALU.
- EXEC_I: alu_type=10, alu_func=instr function, alu_src_b=1 -> WB_ALU.
- EXEC_S: alu_type=11, alu_func=instr function. alu_src_b=1 for function 00000/00001, 0 for 00010/00011. Next WB_ALU.
- MEM_ADDR: alu_type=10, alu_func=00010 (LW) or 00011 (SW), alu_src_b=1 -> MEM_RD or MEM_WR.
- MEM_RD: mem_read=1, iord=1; on mem_ready -> WB_MEM.
- MEM_WR: mem_write=1, iord=1; on mem_ready -> FETCH and retire.
- WB_ALU: reg_write=1, mem_to_reg=0 -> FETCH, retire.
- WB_MEM: reg_write=1, mem_to_reg=1 -> FETCH, retire.
- BRANCH: alu_type=00, alu_func=00010 (SUB), alu_src_b=0; pc_write=zero, pc_src=01 -> FETCH, retire.
- JUMP: pc_write=1, pc_src=10 -> FETCH, retire.
- Timeout counter: counts consecutive cycles in FETCH/MEM_RD/MEM_WR with mem_ready=0 and clears on any state change. When it reaches MEM_TIMEOUT with mem_ready still 0, next state is TRAP, cause 10. If mem_ready rises on the same cycle the count reaches MEM_TIMEOUT, mem_ready wins and no trap occurs.
- TRAP: all enables 0, trap=1; terminal until reset. trap_cause is latched on entry.
- retired: increments by 1 on each retire event and saturates at all-ones (no wrap).

Test Plan:
- Reset, then instr=R ADD (00_00001), mem_ready=1 constant -> states 0,1,2,8,0; reg_write=1 only in state 8; alu_type=00, alu_func=00001 in state 2; retired=1.
- LW with mem_ready delayed 3 cycles in MEM_RD -> mem_read=1, iord=1 held 4 cycles; then WB_MEM with mem_to_reg=1; 6+3 cycles total; retired=1.
- BEQ with zero=1, then with zero=0 -> BRANCH pc_write=1/pc_src=01 and pc_write=0 respectively; both retire; alu_func=00010, alu_type=00.
- instr type 01 function 00111 -> TRAP after DECODE; trap=1, trap_cause=01; fetch never resumes; reset clears trap and returns state=0.
- mem_ready held 0 in FETCH with MEM_TIMEOUT=4 -> TRAP with cause 10 after 4 wait cycles; repeat with mem_ready=1 on the 4th cycle -> DECODE, no trap.
- Assert reset during MEM_WR -> mem_write drops immediately, state=0, retired=0; force retired to all-ones then retire once more -> stays all-ones.
